da_filter_ctrl: RTL and testbench

Sequencer for the bit-serial distributed-arithmetic (DA) FIR datapath. It accepts one input sample per valid/ready handshake and loads the tap delay line and the parallel-load shift registers. It then walks DATA_W bit-serial cycles, driving the shift enables and the accumulator shift-add/subtract controls. It finally holds the result valid until the downstream consumer takes it.

---
 rtl/da_filter_ctrl_pkg.sv | 10 +
 rtl/da_filter_ctrl_if.sv | 23 ++
 rtl/da_filter_ctrl_bit_cnt.sv | 16 +
 rtl/da_filter_ctrl.sv | 52 +++++
 tb/tb_da_filter_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/da_filter_ctrl_pkg.sv
// da_pkg: shared state type, default sample width and bit-index width helper
// for the DA FIR controller and its datapath register instances.
package da_pkg;
    localparam int DA_DATA_W = 20;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} da_ctrl_state_t;
    // A 1-bit sample still needs a 1-bit index.
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/da_filter_ctrl_if.sv
// da_filter_ctrl_if: sample/result handshakes plus datapath controls of the DA FIR sequencer.
interface da_filter_ctrl_if #(parameter int DATA_W = da_pkg::DA_DATA_W);
    localparam int CNT_W = da_pkg::cnt_w(DATA_W);
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic tap_we;
    logic sr_en;
    logic acc_clr;
    logic acc_en;
    logic acc_sub;
    logic [CNT_W-1:0] bit_idx;
    logic busy;
    modport master (
        input in_valid, out_ready,
        output in_ready, out_valid, tap_we, sr_en, acc_clr, acc_en, acc_sub, bit_idx, busy
    );
    modport slave (
        output in_valid, out_ready,
        input in_ready, out_valid, tap_we, sr_en, acc_clr, acc_en, acc_sub, bit_idx, busy
    );
endinterface

// File: rtl/da_filter_ctrl_bit_cnt.sv
// da_bit_cnt: modulo-DATA_W bit index counter with terminal-count flag.
module da_bit_cnt #(
    parameter int DATA_W = da_pkg::DA_DATA_W,
    localparam int CNT_W = da_pkg::cnt_w(DATA_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    assign last = cnt == CNT_W'(DATA_W - 1);
    always_ff @(posedge clk)
        cnt <= (rst || clr || (en && last)) ? '0 : en ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/da_filter_ctrl.sv
// da_filter_ctrl: IDLE/SHIFT/DONE sequencer for the bit-serial DA FIR datapath.
// Define DA_CTRL_OVERLAP_EN to accept the next sample in the result handshake cycle.
module da_filter_ctrl import da_pkg::*; #(
    parameter int DATA_W = DA_DATA_W
) (
    input logic clk,
    input logic rst,
    da_filter_ctrl_if.master bus
);
    localparam int CNT_W = cnt_w(DATA_W);
    da_ctrl_state_t state;
    logic [CNT_W-1:0] cnt;
    logic last;
    logic ready;
    logic accept;
    logic shifting;
    da_bit_cnt #(.DATA_W(DATA_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (shifting),
        .cnt (cnt),
        .last(last)
    );
`ifdef DA_CTRL_OVERLAP_EN
    assign ready = !rst && (state == IDLE || (state == DONE && bus.out_ready));
`else
    assign ready = !rst && state == IDLE;
`endif
    assign accept        = ready && bus.in_valid;
    assign shifting      = !rst && state == SHIFT;
    assign bus.in_ready  = ready;
    assign bus.tap_we    = accept;
    assign bus.acc_clr   = accept;
    assign bus.sr_en     = shifting;
    assign bus.acc_en    = shifting;
    assign bus.acc_sub   = shifting && last;
    assign bus.bit_idx   = rst ? '0 : cnt;
    assign bus.out_valid = !rst && state == DONE;
    assign bus.busy      = !rst && state != IDLE;
    // Reset anywhere drops the in-flight result without a valid pulse.
    always_ff @(posedge clk)
        if (rst)
            state <= IDLE;
        else
            case (state)
                IDLE:    state <= accept ? SHIFT : IDLE;
                SHIFT:   state <= last ? DONE : SHIFT;
                DONE:    state <= !bus.out_ready ? DONE : accept ? SHIFT : IDLE;
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_da_filter_ctrl.sv
// tb_da_filter_ctrl: cycle-exact scoreboard checks of the DA FIR sequencer at DATA_W 20, 4 and 1.
module tb_da_filter_ctrl;
    typedef struct packed {
        logic in_ready;
        logic out_valid;
        logic tap_we;
        logic acc_clr;
        logic sr_en;
        logic acc_en;
        logic acc_sub;
        logic busy;
        logic [4:0] bit_idx;
    } obs_t;
`ifdef DA_CTRL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif
    localparam int P4 = OVL ? 5 : 6;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_err = 0;
    obs_t exp_q[$];
    always #5 clk = ~clk;
    da_filter_ctrl_if #(.DATA_W(20)) b20();
    da_filter_ctrl_if #(.DATA_W(4))  b4();
    da_filter_ctrl_if #(.DATA_W(1))  b1();
    da_filter_ctrl #(.DATA_W(20)) dut20(.clk(clk), .rst(rst), .bus(b20));
    da_filter_ctrl #(.DATA_W(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));
    da_filter_ctrl #(.DATA_W(1))  dut1 (.clk(clk), .rst(rst), .bus(b1));
    function automatic obs_t mk(bit ir, bit ov, bit tw, bit sh, bit sub, bit by, logic [4:0] idx);
        return '{ir, ov, tw, tw, sh, sh, sub, by, idx};
    endfunction
    function automatic obs_t get(int w);
        obs_t o;
        o = '0;
        case (w)
            20: o = '{b20.in_ready, b20.out_valid, b20.tap_we, b20.acc_clr, b20.sr_en, b20.acc_en, b20.acc_sub, b20.busy, 5'(b20.bit_idx)};
            4:  o = '{b4.in_ready, b4.out_valid, b4.tap_we, b4.acc_clr, b4.sr_en, b4.acc_en, b4.acc_sub, b4.busy, 5'(b4.bit_idx)};
            default: o = '{b1.in_ready, b1.out_valid, b1.tap_we, b1.acc_clr, b1.sr_en, b1.acc_en, b1.acc_sub, b1.busy, 5'(b1.bit_idx)};
        endcase
        return o;
    endfunction
    task automatic test_reset();
        obs_t e, o;
        for (int c = 0; c < 4; c++) begin
            rst = c < 3;
            b20.in_valid = c < 3;
            b1.in_valid = c < 3;
            exp_q.push_back(c < 3 ? obs_t'('0) : mk(1, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = get(20);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL reset20 c=%0d got=%h exp=%h", c, o, e); end
            o = get(1);
            n_cmp++;
            if (o !== (c < 3 ? obs_t'('0) : mk(1, 0, 0, 0, 0, 0, 0))) begin n_err++; $display("FAIL reset1 c=%0d got=%h", c, o); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_single();
        obs_t e, o;
        b20.out_ready = 1'b1;
        for (int c = 0; c <= 22; c++) begin
            b20.in_valid = c == 0;
            exp_q.push_back(c == 0 ? mk(1, 0, 1, 0, 0, 0, 0) :
                            c <= 20 ? mk(0, 0, 0, 1, c == 20, 1, 5'(c - 1)) :
                            c == 21 ? mk(OVL, 1, 0, 0, 0, 1, 0) : mk(1, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = get(20);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL single c=%0d got=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_backpressure();
        obs_t e, o;
        for (int c = 0; c <= 27; c++) begin
            b20.in_valid = 1'b1;
            b20.out_ready = !(c >= 21 && c <= 25);
            exp_q.push_back(c == 0 ? mk(1, 0, 1, 0, 0, 0, 0) :
                            c <= 20 ? mk(0, 0, 0, 1, c == 20, 1, 5'(c - 1)) :
                            c <= 25 ? mk(0, 1, 0, 0, 0, 1, 0) :
                            c == 26 ? mk(OVL, 1, OVL, 0, 0, 1, 0) :
                            OVL ? mk(0, 0, 0, 1, 0, 1, 0) : mk(1, 0, 1, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = get(20);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL backpressure c=%0d got=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
        b20.in_valid = 1'b0;
        b20.out_ready = 1'b1;
    endtask
    task automatic test_mid_reset();
        obs_t e, o;
        bit rs;
        for (int c = 0; c <= 63; c++) begin
            rs = c == 0 || c == 10 || c == 11;
            rst = rs;
            b20.in_valid = c == 1 || c == 41;
            exp_q.push_back(rs ? obs_t'('0) :
                            (c == 1 || c == 41) ? mk(1, 0, 1, 0, 0, 0, 0) :
                            (c >= 2 && c <= 9) ? mk(0, 0, 0, 1, 0, 1, 5'(c - 2)) :
                            (c >= 42 && c <= 61) ? mk(0, 0, 0, 1, c == 61, 1, 5'(c - 42)) :
                            c == 62 ? mk(OVL, 1, 0, 0, 0, 1, 0) : mk(1, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = get(20);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL mid_reset c=%0d got=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask
    task automatic test_back_to_back();
        obs_t e, o;
        int ph;
        b4.out_ready = 1'b1;
        b4.in_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            ph = c % P4;
            exp_q.push_back(ph == 0 ? ((c == 0 || !OVL) ? mk(1, 0, 1, 0, 0, 0, 0) : mk(1, 1, 1, 0, 0, 1, 0)) :
                            ph <= 4 ? mk(0, 0, 0, 1, ph == 4, 1, 5'(ph - 1)) : mk(0, 1, 0, 0, 0, 1, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = get(4);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
        b4.in_valid = 1'b0;
    endtask
    task automatic test_width1();
        obs_t e, o;
        b1.out_ready = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            b1.in_valid = c == 0;
            exp_q.push_back(c == 0 ? mk(1, 0, 1, 0, 0, 0, 0) :
                            c == 1 ? mk(0, 0, 0, 1, 1, 1, 0) :
                            c == 2 ? mk(OVL, 1, 0, 0, 0, 1, 0) : mk(1, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            o = get(1);
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL width1 c=%0d got=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        b20.in_valid = 1'b0; b20.out_ready = 1'b0;
        b4.in_valid = 1'b0;  b4.out_ready = 1'b0;
        b1.in_valid = 1'b0;  b1.out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
